// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory access controller.
// Runs each load/store as a fixed-length multi-cycle SRAM access and stalls the
// pipeline through 'ready' while the access is in flight.
module mem_stage_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              is_store;
  logic              req;
  logic [ADDR_W-1:0] word;

  // A store wins when both request lines are raised, so only the OR matters here.
  assign req  = MEM_R_EN | MEM_W_EN;
  // Byte address relative to the SRAM window, word-aligned; upper bits wrap away.
  assign word = ADDR_W'((ALU_Res - 32'(BASE_ADDR)) >> 2);

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: DONE always returns to IDLE so the frozen old request is not replayed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the request in IDLE, count access cycles, latch load data on the last one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      is_store   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_store   <= MEM_W_EN;
            sram_addr  <= word;
            sram_wdata <= Val_Rm;
            cnt        <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!is_store) rdata <= sram_rdata;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and strobes: ready drops the same cycle a request shows up; strobes live only in ACCESS.
  always_comb begin
    ready     = 1'b0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    ready     = !rst || (state == IDLE && !req) || (state == DONE);
    sram_we_n = !(state == ACCESS && is_store);
    sram_oe_n = !(state == ACCESS && !is_store);
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl with a behavioural SRAM.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic        ready;
  logic [31:0] rdata;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          we_cycles;
    int          oe_cycles;
    int          busy;
  } exp_t;

  exp_t expq[$];
  int checks     = 0;
  int failures   = 0;
  int done_count = 0;
  int stray      = 0;
  int busy_cnt   = 0;
  int we_cnt     = 0;
  int oe_cnt     = 0;

  logic [31:0] mem [logic [15:0]];

  mem_stage_ctrl #(.WAIT_CYCLES(4), .ADDR_W(16), .BASE_ADDR(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_Res    (ALU_Res),
    .Val_Rm     (Val_Rm),
    .ready      (ready),
    .rdata      (rdata),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  // 100 MHz style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: writes land while we_n is low; read data follows the address, unwritten words read F00D_<addr>.
  always @(negedge clk) begin
    if (!sram_we_n) mem[sram_addr] = sram_wdata;
    if (mem.exists(sram_addr)) sram_rdata = mem[sram_addr];
    else                       sram_rdata = {16'hF00D, sram_addr};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Monitor: measure each access while ready is low, then score it against the queue when ready returns.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
      we_cnt   = 0;
      oe_cnt   = 0;
    end else if (!ready) begin
      busy_cnt++;
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n) oe_cnt++;
    end else begin
      if (!sram_we_n || !sram_oe_n) stray++;
      if (busy_cnt > 0) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_completion", 32'(busy_cnt), 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          checkOutput("rdata", rdata, e.rdata);
          checkOutput("sram_addr", {16'h0, sram_addr}, e.addr);
          checkOutput("sram_wdata", sram_wdata, e.wdata);
          checkOutput("we_cycles", 32'(we_cnt), 32'(e.we_cycles));
          checkOutput("oe_cycles", 32'(oe_cnt), 32'(e.oe_cycles));
          checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        done_count++;
        busy_cnt = 0;
        we_cnt   = 0;
        oe_cnt   = 0;
      end
    end
  end

  // Issue one request, held for n back-to-back accesses; expected results are hand-computed by the caller.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] exp_rdata, input logic [31:0] exp_word,
                               input int exp_we, input int exp_oe, input int n);
    exp_t e;
    int target;
    int guard;
    e.rdata     = exp_rdata;
    e.addr      = exp_word;
    e.wdata     = data;
    e.we_cycles = exp_we;
    e.oe_cycles = exp_oe;
    e.busy      = 5;
    for (int i = 0; i < n; i++) expq.push_back(e);
    target = done_count + n;
    @(posedge clk);
    #1;
    MEM_R_EN = r;
    MEM_W_EN = w;
    ALU_Res  = addr;
    Val_Rm   = data;
    guard = 0;
    while (done_count < target && guard < 60) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (done_count < target) checkOutput("completion_timeout", 32'(done_count), 32'(target));
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res  = '0;
    Val_Rm   = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {31'h0, ready}, 32'd1);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_we_n", {31'h0, sram_we_n}, 32'd1);
    checkOutput("reset_oe_n", {31'h0, sram_oe_n}, 32'd1);
    checkOutput("reset_addr", {16'h0, sram_addr}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Store 0xDEADBEEF to byte 1032 -> word 2.
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0, 32'd2, 4, 0, 1);
    // Load it back.
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h11111111, 32'hDEADBEEF, 32'd2, 0, 4, 1);
    // Load from 1036 held through DONE: exactly two accesses of unwritten word 3.
    applyStimulus(1'b1, 1'b0, 32'd1036, 32'h22222222, 32'hF00D0003, 32'd3, 0, 4, 2);
    // Both enables at 1027: store to word 0, rdata keeps the previous load.
    applyStimulus(1'b1, 1'b1, 32'd1027, 32'h12345678, 32'hF00D0003, 32'd0, 4, 0, 1);
    // Confirm word 0 was written.
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, 32'd0, 0, 4, 1);
    // Address below the window wraps to word 0xFFFF.
    applyStimulus(1'b1, 1'b0, 32'd1020, 32'h0, 32'hF00DFFFF, 32'hFFFF, 0, 4, 1);

    // Reset during the second ACCESS cycle of a load aborts it.
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1024;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    @(negedge clk);
    checkOutput("ready_forced_in_reset", {31'h0, ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", {31'h0, ready}, 32'd1);
    checkOutput("abort_we_n", {31'h0, sram_we_n}, 32'd1);
    checkOutput("abort_oe_n", {31'h0, sram_oe_n}, 32'd1);
    checkOutput("abort_rdata", rdata, 32'h0);
    // A fresh load then completes normally.
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, 32'd0, 0, 4, 1);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("queue_empty", 32'(expq.size()), 32'd0);
    checkOutput("completions", 32'(done_count), 32'd8);
    checkOutput("stray_strobes", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
